// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control sequencer for the 16-bit multicycle processor
module multicycle_control_fsm #(
  parameter int OPW = 4,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           BranchSel,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           halted,
  output logic [STW-1:0] state
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC      = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11,
    S_IMM_EXEC  = 4'd12,
    S_IMM_WB    = 4'd13
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_LW   = OPW'(1);
  localparam logic [OPW-1:0] OP_SW   = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(3);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_J    = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);

  state_t state_q, state_d;

  // Next-state selection; only the three memory states look at mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_R:            state_d = S_EXEC;
          OP_ADDI:         state_d = S_IMM_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC:      state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_IMM_EXEC:  state_d = S_IMM_WB;
      S_IMM_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_INIT;
    endcase
  end

  // State register; async reset drops to INIT so every strobe falls at once
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Moore output decode; FETCH gates IR/PC load on mem_ready so PC+2 lands with the IR
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchSel   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:    ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IMM_WB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchSel   = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_HALT:      halted = 1'b1;
      default: ;
    endcase
  end

  assign state = STW'(state_q);

endmodule
